// File: rtl/inbuf_port.sv
// Router input buffer: a small flit FIFO plus a per-packet FSM. The FSM latches the
// output port from the header, forwards the packet and discards stray body/tail flits.
module inbuf_port #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        in_flit,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [FLIT_W-1:0]        head_flit,
  input  logic [4:0]               route_en,
  output logic [FLIT_W-1:0]        out_flit,
  output logic                     out_valid,
  output logic [4:0]               out_port,
  input  logic                     out_grant,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [0:0]        state_reg;
  logic [4:0]        out_port_reg;
  logic              err_drop_reg;

  logic              wr_en;
  logic              rd_en;
  logic              not_empty;
  logic [1:0]        head_type;
  logic              route_onehot;
  logic              drop_now;
  logic              accept_hdr;
  logic              tail_read;

  assign not_empty = (count_reg != '0);
  assign in_ready  = (count_reg < CW'(DEPTH));
  assign wr_en     = in_valid && in_ready;

  assign head_flit = not_empty ? mem[rd_ptr_reg] : '0;
  assign out_flit  = head_flit;
  assign head_type = head_flit[7:6];

  assign route_onehot = (route_en != 5'd0) && ((route_en & (route_en - 5'd1)) == 5'd0);

  // Type bit 7 separates packet starters (HDR/SINGLE) from BODY/TAIL; bit 6 marks the end.
  assign drop_now   = (state_reg == IDLE) && not_empty && !head_type[1];
  assign accept_hdr = (state_reg == IDLE) && not_empty && head_type[1] && route_onehot;

  assign out_valid = (state_reg == ACTIVE) && not_empty;
  assign tail_read = out_valid && out_grant && head_type[0];
  assign rd_en     = (out_valid && out_grant) || drop_now;

  assign out_port = out_port_reg;
  assign count    = count_reg;
  assign err_drop = err_drop_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= in_flit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      out_port_reg <= 5'd0;
      err_drop_reg <= 1'b0;
    end else begin
      err_drop_reg <= drop_now;
      case (state_reg)
        IDLE: begin
          if (accept_hdr) begin
            out_port_reg <= route_en;
            state_reg    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (tail_read) begin
            out_port_reg <= 5'd0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          state_reg    <= IDLE;
          out_port_reg <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inbuf_port.sv
// Directed bench for inbuf_port: stimulus pushes expected flits into a scoreboard,
// a negedge monitor pops and compares every granted transfer.
module tb_inbuf_port;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_flit;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] head_flit;
  logic [4:0] route_en;
  logic [7:0] out_flit;
  logic       out_valid;
  logic [4:0] out_port;
  logic       out_grant;
  logic [2:0] count;
  logic       err_drop;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  logic [12:0] exp_q [$];

  inbuf_port #(.DEPTH(4), .FLIT_W(8)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .head_flit(head_flit), .route_en(route_en), .out_flit(out_flit), .out_valid(out_valid),
    .out_port(out_port), .out_grant(out_grant), .count(count), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [7:0] f, input logic [4:0] p);
    exp_q.push_back({p, f});
  endtask

  // Inputs change 1 time unit after posedge, so at negedge they hold for the next edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (err_drop) err_seen++;
      if (out_valid && out_grant) begin
        $display("xfer flit=%02h port=%05b t=%0t", out_flit, out_port, $time);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got flit %02h expected none", out_flit);
        end else begin
          logic [12:0] e;
          e = exp_q.pop_front();
          check("sb_flit", {24'd0, out_flit}, {24'd0, e[7:0]});
          check("sb_port", {27'd0, out_port}, {27'd0, e[12:8]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_flit = 8'h00; in_valid = 1'b0; route_en = 5'd0; out_grant = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_port", out_port, 0);
    check("rst_err_drop", err_drop, 0);
    check("rst_head", head_flit, 0);
    #11 rst = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // Single packet, grant always high
    route_en = 5'b00010; out_grant = 1'b1;
    sb_push(8'h85, 5'b00010); sb_push(8'h00, 5'b00010); sb_push(8'h40, 5'b00010);
    in_flit = 8'h85; in_valid = 1'b1; tick();
    check("t1_cnt_t", count, 1);
    check("t1_port_t", out_port, 0);
    check("t1_valid_t", out_valid, 0);
    in_flit = 8'h00; tick();
    check("t1_port_t1", out_port, 5'b00010);
    check("t1_valid_t1", out_valid, 1);
    check("t1_cnt_t1", count, 2);
    in_flit = 8'h40; tick();
    check("t1_cnt_t2", count, 2);
    in_valid = 1'b0; tick();
    check("t1_cnt_t3", count, 1);
    tick();
    check("t1_cnt_end", count, 0);
    check("t1_port_end", out_port, 0);
    check("t1_valid_end", out_valid, 0);
    out_grant = 1'b0;

    // Full buffer
    route_en = 5'b00100;
    sb_push(8'h8A, 5'b00100); sb_push(8'h01, 5'b00100);
    sb_push(8'h02, 5'b00100); sb_push(8'h43, 5'b00100);
    in_valid = 1'b1;
    in_flit = 8'h8A; tick();
    in_flit = 8'h01; tick();
    in_flit = 8'h02; tick();
    in_flit = 8'h43; tick();
    check("t2_cnt_full", count, 4);
    check("t2_ready_full", in_ready, 0);
    in_flit = 8'h55; tick();
    check("t2_cnt_5th", count, 4);
    in_valid = 1'b0; out_grant = 1'b1; tick();
    out_grant = 1'b0;
    check("t2_cnt_after_rd", count, 3);
    check("t2_ready_after_rd", in_ready, 1);
    out_grant = 1'b1;
    repeat (3) tick();
    out_grant = 1'b0;
    check("t2_cnt_drain", count, 0);
    check("t2_port_drain", out_port, 0);

    // Stray BODY flit into idle buffer
    route_en = 5'b00010;
    in_flit = 8'h03; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    check("t3_cnt_t", count, 1);
    check("t3_valid_t", out_valid, 0);
    tick();
    check("t3_err_pulse", err_drop, 1);
    check("t3_cnt_drop", count, 0);
    check("t3_valid_drop", out_valid, 0);
    tick();
    check("t3_err_clear", err_drop, 0);

    // Bad route held, then valid route; out_port stable in ACTIVE
    route_en = 5'b00000;
    sb_push(8'h81, 5'b10000); sb_push(8'h42, 5'b10000);
    in_flit = 8'h81; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_port", out_port, 0);
      check("t4_hold_valid", out_valid, 0);
      check("t4_hold_cnt", count, 1);
    end
    route_en = 5'b10000; tick();
    check("t4_port_act", out_port, 5'b10000);
    check("t4_valid_act", out_valid, 1);
    route_en = 5'b00001; tick();
    check("t4_port_stable", out_port, 5'b10000);
    out_grant = 1'b1; in_flit = 8'h42; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    check("t4_cnt_rw", count, 1);
    tick();
    out_grant = 1'b0;
    check("t4_cnt_end", count, 0);
    check("t4_port_end", out_port, 0);

    // Simultaneous read/write at count 2 across pointer wrap
    route_en = 5'b00001;
    sb_push(8'h90, 5'b00001); sb_push(8'h11, 5'b00001); sb_push(8'h12, 5'b00001);
    sb_push(8'h13, 5'b00001); sb_push(8'h54, 5'b00001);
    in_valid = 1'b1;
    in_flit = 8'h90; tick();
    in_flit = 8'h11; tick();
    check("t5_cnt_pre", count, 2);
    out_grant = 1'b1;
    in_flit = 8'h12; tick();
    check("t5_cnt_rw1", count, 2);
    in_flit = 8'h13; tick();
    check("t5_cnt_rw2", count, 2);
    in_flit = 8'h54; tick();
    check("t5_cnt_rw3", count, 2);
    in_valid = 1'b0; tick();
    check("t5_cnt_d1", count, 1);
    tick();
    out_grant = 1'b0;
    check("t5_cnt_end", count, 0);
    check("t5_port_end", out_port, 0);

    // SINGLE then back-to-back packet
    route_en = 5'b01000; out_grant = 1'b1;
    sb_push(8'hC6, 5'b01000); sb_push(8'h87, 5'b01000); sb_push(8'h48, 5'b01000);
    in_valid = 1'b1;
    in_flit = 8'hC6; tick();
    in_flit = 8'h87; tick();
    check("t7_port_single", out_port, 5'b01000);
    in_flit = 8'h48; tick();
    in_valid = 1'b0;
    check("t7_idle_port", out_port, 0);
    check("t7_idle_valid", out_valid, 0);
    check("t7_idle_cnt", count, 2);
    tick();
    check("t7_port_next", out_port, 5'b01000);
    tick();
    tick();
    out_grant = 1'b0;
    check("t7_cnt_end", count, 0);
    check("t7_port_end", out_port, 0);

    // Reset mid-packet; later TAIL is dropped
    route_en = 5'b00010;
    in_valid = 1'b1;
    in_flit = 8'h85; tick();
    in_flit = 8'h00; tick();
    in_valid = 1'b0;
    check("t6_active", out_port, 5'b00010);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_cnt", count, 0);
    check("t6_rst_port", out_port, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_ready", in_ready, 1);
    check("t6_rst_err", err_drop, 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    out_grant = 1'b1;
    in_flit = 8'h40; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    check("t6_cnt_tail", count, 1);
    check("t6_valid_tail", out_valid, 0);
    tick();
    check("t6_err_pulse", err_drop, 1);
    check("t6_cnt_drop", count, 0);
    tick();
    out_grant = 1'b0;
    check("t6_err_clear", err_drop, 0);
    check("t6_port_idle", out_port, 0);

    tick();
    check("sb_empty", exp_q.size(), 0);
    check("err_drop_total", err_seen, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inbuf_port.md
INBUF_PORT -- requirements
Module: inbuf_port

Interface
- REQ-001 SHALL have parameter DEPTH, default 4: FIFO depth in flits, a power of two.
- REQ-002 SHALL have parameter FLIT_W, default 8: flit width.
  - Bits [7:6] are the flit type: 2'b10 HDR, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE (header and tail in one flit).
  - Bits [3:0] are the destination: x in [3:2], y in [1:0].
- REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
- REQ-005 SHALL have port in_flit, input, FLIT_W: flit from the upstream link.
- REQ-006 SHALL have port in_valid, input, 1: in_flit is valid.
- REQ-007 SHALL have port in_ready, output, 1: the buffer can accept a flit this cycle.
- REQ-008 SHALL have port head_flit, output, FLIT_W: flit at the FIFO head. It feeds the route-compute Li input.
- REQ-009 SHALL have port route_en, input, 5: {e5,e4,e3,e2,e1} one-hot route (local, east, west, south, north) returned from route compute for head_flit.
- REQ-010 SHALL have port out_flit, output, FLIT_W: flit presented to the crossbar.
- REQ-011 SHALL have port out_valid, output, 1: out_flit is valid for the latched output port.
- REQ-012 SHALL have port out_port, output, 5: one-hot output port request, latched per packet.
- REQ-013 SHALL have port out_grant, input, 1: downstream accepts out_flit this cycle.
- REQ-014 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy.
- REQ-015 SHALL have port err_drop, output, 1: one-cycle pulse when a stray flit is discarded.

Function
- REQ-016 SHALL write in_flit at the edge where in_valid && in_ready; in_ready = (count < DEPTH), combinational.
- REQ-017 SHALL read the head at the edge where out_valid && out_grant.
- REQ-018 SHALL wrap read and write pointers modulo DEPTH.
  - count: +1 on write only, -1 on read only, unchanged on simultaneous read and write.
- REQ-019 SHALL drive head_flit = out_flit = mem[rd_ptr] when count>0, else 8'h00.
- REQ-020 SHALL implement the packet FSM in state IDLE:
  - head type HDR or SINGLE and route_en exactly one-hot: latch out_port <= route_en and go to ACTIVE.
  - route_en not one-hot: remain IDLE with no read (the header is held).
- REQ-021 SHALL discard the head flit in IDLE when it is BODY or TAIL: pop one entry, pulse err_drop for one cycle, stay IDLE.
- REQ-022 SHALL drive out_valid = (state==ACTIVE) && (count>0); out_valid is never asserted in IDLE.
- REQ-023 SHALL return ACTIVE to IDLE at the edge where a TAIL or SINGLE flit is read.
  - out_port clears to 5'b0 at the same edge.
  - Reads of HDR or BODY stay in ACTIVE.
- REQ-024 SHALL hold out_port constant in ACTIVE regardless of route_en changes.
- REQ-025 SHALL ignore out_grant when out_valid=0, and ignore in_valid when in_ready=0 (that flit is not stored).
- REQ-026 SHALL give a minimum latency, header into an empty buffer, of:
  - write at edge t;
  - ACTIVE and out_port valid after edge t+1;
  - earliest read at edge t+2.
- REQ-027 SHALL allow back-to-back packets: a new header at the head after a tail read is evaluated in IDLE on the following edge.

Reset
- REQ-028 SHALL, while rst=0, immediately and asynchronously force:
  - state IDLE, pointers 0, count 0;
  - out_port 5'b0, out_valid 0, err_drop 0;
  - in_ready 1 (after deassertion); FIFO contents don't-care.
- REQ-029 SHALL abandon any packet when reset asserts mid-packet; after release, the remaining body/tail flits arriving are dropped per REQ-021.

Verification
- REQ-030 SHALL cover the single packet case:
  - stimulus: write HDR 8'h85, BODY 8'h00, TAIL 8'h40 with route_en=5'b00010 and out_grant=1.
  - response: out_port=5'b00010 from edge t+1, three flits out on consecutive cycles, then IDLE.
- REQ-031 SHALL cover the full buffer case:
  - stimulus: write 4 flits with out_grant=0.
  - response: count=4, in_ready=0; a 5th in_valid is not stored; grant one flit, then in_ready=1 the next cycle.
- REQ-032 SHALL cover the stray flit case:
  - stimulus: BODY 8'h03 into an empty IDLE buffer.
  - response: err_drop pulses once, count returns to 0, out_valid stays 0.
- REQ-033 SHALL cover the bad route case:
  - stimulus: HDR at head with route_en=5'b00000 for 3 cycles, then 5'b10000.
  - response: state stays IDLE, then ACTIVE with out_port=5'b10000.
- REQ-034 SHALL cover simultaneous read and write:
  - stimulus: count=2, write and read in the same cycle.
  - response: count stays 2 and flit order is preserved across pointer wrap.
- REQ-035 SHALL cover reset mid-packet:
  - stimulus: assert rst=0 between header and tail.
  - response: outputs reset immediately; the later TAIL is dropped with err_drop.
